dmem_responder: RTL and testbench

Responder side of the data-memory port driven by the memory stage of the five-stage RISC-V pipeline. It accepts one load or store request at a time over a valid/ready handshake and models a configurable access latency. It performs byte, half-word and word accesses with little-endian lane alignment and sign/zero extension, and returns a response (read data or store acknowledge, plus error flag) over a second valid/ready handshake. It replaces the single-cycle array behind the memory stage whenever multi-cycle memory timing must be exercised.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 52 +++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word-index width for a given array depth; a one-word array still needs one bit.
  function automatic int unsigned addr_width(input int unsigned depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables / data replication, load extraction / extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store path: enable the addressed lanes and replicate data across all lanes.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      default: ;
    endcase
  end

  // Load path: pick the addressed lanes and extend to 32 bits.
  always_comb begin
    byte_sel = 8'(rword_i >> {lane_i, 3'b000});
    half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    rdata_o  = 32'h0;
    case (size_i)
      SZ_BYTE: rdata_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: rdata_o = rword_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, configurable latency, registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = addr_width(DEPTH_WORDS);
  localparam int unsigned CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [32:0] ADDR_LIMIT = 33'(64'(DEPTH_WORDS) * 64'd4);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              direct_c;
  logic              cur_we;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic              commit_c;
  logic              err_c;
  logic [AW-1:0]     word_idx;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       load_data;
  logic [31:0]       rsp_rdata_d;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With single-cycle latency the commit happens on the accept edge, straight from the inputs.
  always_comb begin
    direct_c  = (LATENCY == 1) && (state_q == IDLE);
    cur_we    = direct_c ? req_we       : we_q;
    cur_size  = direct_c ? req_size     : size_q;
    cur_uns   = direct_c ? req_unsigned : uns_q;
    cur_addr  = direct_c ? req_addr     : addr_q;
    cur_wdata = direct_c ? req_wdata    : wdata_q;
    commit_c  = (LATENCY == 1) ? (req_valid && state_q == IDLE)
                               : (state_q == WAIT && cnt_q == '0);
  end

  // Illegal size, misalignment or address beyond the array.
  always_comb begin
    err_c = (cur_size == 2'b11)
         || (cur_size == SZ_HALF && cur_addr[0] != 1'b0)
         || (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00)
         || ({1'b0, cur_addr} >= ADDR_LIMIT);
    word_idx    = cur_addr[AW+1:2];
    rword       = mem_q[word_idx];
    rsp_rdata_d = (cur_we || err_c) ? 32'h0 : load_data;
  end

  dmem_lane_align u_align (
    .size_i     (cur_size),
    .unsigned_i (cur_uns),
    .lane_i     (cur_addr[1:0]),
    .wdata_i    (cur_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .rdata_o    (load_data)
  );

  // Request/response FSM with latency counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (LATENCY == 1) begin
              state_q     <= RESP;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= err_c;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(CNT_INIT);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= err_c;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte-lane array write on the commit edge of an error-free store; reset blocks it.
  always_ff @(posedge clk) begin
    if (!rst && commit_c && cur_we && !err_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[word_idx][8*k +: 8] <= wdata_rep[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder (LATENCY 2 and LATENCY 1 instances).
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        rst1, req_valid1, req_ready1, req_we1, req_unsigned1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [1:0]  req_size1;
  logic [31:0] req_addr1, req_wdata1, rsp_rdata1;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [0:4095];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_size(req_size1), .req_unsigned(req_unsigned1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  // Byte-addressed reference memory: error rules, lane writes and extension by plain arithmetic.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic exp_err, output logic [31:0] exp_rdata);
    int n;
    logic [31:0] v;
    exp_rdata = 32'h0;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd4096);
    if (exp_err) return;
    n = 1 << size;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + 32'(i)]) << (8*i));
      if (!uns && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      exp_rdata = v;
    end
  endtask

  // One full transaction on the LATENCY=2 instance; lat counts edges from accept to rsp_valid.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout addr=%h: no rsp_valid within 20 cycles", addr);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    if (req_ready1 !== 1'b1) begin errors++; $display("FAIL reset1_req_ready got %b exp 1", req_ready1); end
    if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL reset1_rsp_valid got %b exp 0", rsp_valid1); end
    if (rsp_rdata1 !== 32'h0) begin errors++; $display("FAIL reset1_rsp_rdata got %h exp 0", rsp_rdata1); end
    if (rsp_err1 !== 1'b0) begin errors++; $display("FAIL reset1_rsp_err got %b exp 0", rsp_err1); end
    rst = 1'b0; rst1 = 1'b0;
  endtask

  task automatic test_word_round_trip();
    logic [31:0] r, er; logic e, ee; int lat;
    model(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, ee, er);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, r, e, lat);
    checks += 3;
    if (e !== 1'b0 || r !== 32'h0) begin errors++; $display("FAIL store_word_rsp got err=%b rdata=%h exp 0/0", e, r); end
    if (lat != 2) begin errors++; $display("FAIL store_latency got %0d exp 2", lat); end
    if (ee !== 1'b0) begin errors++; $display("FAIL store_model_err got %b exp 0", ee); end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1, r, e, lat);
    checks += 2;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL load_word got %h err=%b exp deadbeef err=0", r, e); end
    if (lat != 2) begin errors++; $display("FAIL load_latency got %0d exp 2", lat); end
  endtask

  task automatic test_byte_extension();
    logic [31:0] r, er; logic e, ee; int lat;
    logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd2, 2'd1};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF, 32'h000080AD};
    model(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, ee, er);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'hAAAAAA80, 0, r, e, lat);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, 0, r, e, lat);
      checks++;
      if (r !== ex[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL byte_ext_%0d got %h err=%b exp %h err=0", i, r, e, ex[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat;
    logic        we [3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] ad [3] = '{32'h11, 32'h1000, 32'h10};
    for (int i = 0; i < 3; i++) begin
      do_req(we[i], sz[i], 1'b0, ad[i], 32'h5555AAAA, 0, r, e, lat);
      checks++;
      if (e !== 1'b1 || r !== 32'h0) begin
        errors++;
        $display("FAIL error_case_%0d got err=%b rdata=%h exp err=1 rdata=0", i, e, r);
      end
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e, lat);
      checks++;
      if (r !== 32'h80ADBEEF || e !== 1'b0) begin
        errors++;
        $display("FAIL error_reload_%0d got %h err=%b exp 80adbeef err=0", i, r, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic e; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h80ADBEEF || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_cyc%0d got valid=%b ready=%b rdata=%h err=%b exp 1/0/80adbeef/0",
                 i, rsp_valid, req_ready, rsp_rdata, rsp_err);
      end
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h11111111;
      end
      if (i == 2) req_valid = 1'b0;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_after%0d got valid=%b ready=%b exp 0/1", i, rsp_valid, req_ready);
      end
      @(negedge clk);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e, lat);
    checks++;
    if (r !== 32'h80ADBEEF) begin errors++; $display("FAIL backpressure_ignored_store got %h exp 80adbeef", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, er; logic e, ee; int lat;
    model(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, ee, er);
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 0, r, e, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got ready=%b valid=%b rdata=%h err=%b exp 1/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, r, e, lat);
    checks++;
    if (r !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL reset_mid_reload got %h exp cafef00d", r); end
  endtask

  task automatic test_random();
    logic [31:0] r, er, a, wd; logic e, ee, we, un; logic [1:0] sz; int lat;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model(1'b1, 2'd2, 1'b0, 32'(4*w), wd, ee, er);
      do_req(1'b1, 2'd2, 1'b0, 32'(4*w), wd, 0, r, e, lat);
    end
    for (int t = 0; t < 80; t++) begin
      we = 1'($urandom); sz = 2'($urandom); un = 1'($urandom); wd = $urandom;
      a = ($urandom % 8 == 0) ? 32'h1000 + 32'($urandom % 64) : 32'($urandom % 64);
      model(we, sz, un, a, wd, ee, er);
      do_req(we, sz, un, a, wd, int'($urandom % 3), r, e, lat);
      checks++;
      if (r !== er || e !== ee || lat != 2) begin
        errors++;
        $display("FAIL random_%0d we=%b sz=%0d un=%b addr=%h got %h err=%b lat=%0d exp %h err=%b lat=2",
                 t, we, sz, un, a, r, e, lat, er, ee);
      end
    end
  endtask

  // LATENCY=1: response the cycle after accept, requests every second cycle with rsp_ready high.
  task automatic test_latency1();
    @(negedge clk);
    rsp_ready1 = 1'b1;
    req_valid1 = 1'b1; req_we1 = 1'b1; req_size1 = 2'd2; req_unsigned1 = 1'b0;
    req_addr1 = 32'h8; req_wdata1 = 32'hA5A55A5A;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (req_ready1 !== 1'((i % 2) == 0) || rsp_valid1 !== 1'((i % 2) == 1)) begin
        errors++;
        $display("FAIL lat1_cyc%0d got ready=%b valid=%b exp %0d/%0d", i, req_ready1, rsp_valid1, (i%2)==0, (i%2)==1);
      end
      if (i == 1) begin
        checks++;
        if (rsp_rdata1 !== 32'h0 || rsp_err1 !== 1'b0) begin
          errors++; $display("FAIL lat1_store_rsp got %h err=%b exp 0/0", rsp_rdata1, rsp_err1);
        end
        req_we1 = 1'b0;
      end
      if (i >= 3 && (i % 2) == 1) begin
        checks++;
        if (rsp_rdata1 !== 32'hA5A55A5A || rsp_err1 !== 1'b0) begin
          errors++; $display("FAIL lat1_load_cyc%0d got %h err=%b exp a5a55a5a/0", i, rsp_rdata1, rsp_err1);
        end
      end
      @(negedge clk);
    end
    req_valid1 = 1'b0;
    rsp_ready1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    rst1 = 1'b1; req_valid1 = 1'b0; req_we1 = 1'b0; req_size1 = 2'd0; req_unsigned1 = 1'b0;
    req_addr1 = 32'h0; req_wdata1 = 32'h0; rsp_ready1 = 1'b0;
    test_reset();
    test_word_round_trip();
    test_byte_extension();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_latency1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
